// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: latches the decoded instruction into EX, resolves the EX destination, inserts load-use bubbles and handles flush/hold.
// Optional IDEX_PERF_CNT_EN adds saturating bubble_cnt / flush_cnt outputs.
module id_ex_stage_reg #(
    parameter int CTRL_W = 22,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [15:0]       id_imm16,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [15:0]       ex_imm16,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dest,
    output logic              stall_req
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [15:0]       bubble_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] pc_q,      pc_d;
    logic [DATA_W-1:0] rs_val_q,  rs_val_d;
    logic [DATA_W-1:0] rt_val_q,  rt_val_d;
    logic [15:0]       imm_q,     imm_d;
    logic [REG_AW-1:0] rs_q,      rs_d;
    logic [REG_AW-1:0] rt_q,      rt_d;
    logic [REG_AW-1:0] dest_q,    dest_d;
    logic              pend_q,    pend_d;
    logic              ex_is_load;
    logic              flush_bubble;
    logic              hazard_bubble;
    logic [REG_AW-1:0] id_dest;

    // Bit 10 is deliberately not used: ADDIU sets it without touching memory.
    assign ex_is_load = valid_q & ctrl_q[0] & ~ctrl_q[4] & ctrl_q[9];

    assign stall_req = rst_n & id_valid & ex_is_load & (dest_q != '0)
                     & ((dest_q == id_rs) | (dest_q == id_rt))
                     & ~hold & ~flush & ~pend_q;

    assign id_dest = id_ctrl[18] ? (id_ctrl[20] ? id_rt : id_rd) : {REG_AW{1'b1}};

    assign flush_bubble  = ~hold & (flush | pend_q);
    assign hazard_bubble = ~hold & ~flush & ~pend_q & stall_req;

    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        pc_d     = pc_q;
        rs_val_d = rs_val_q;
        rt_val_d = rt_val_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        dest_d   = dest_q;
        pend_d   = pend_q;
        if (hold) begin
            pend_d = pend_q | flush;
        end else if (flush_bubble || hazard_bubble) begin
            valid_d  = 1'b0;
            ctrl_d   = '0;
            pc_d     = '0;
            rs_val_d = '0;
            rt_val_d = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
            dest_d   = '0;
            pend_d   = 1'b0;
        end else begin
            valid_d  = id_valid;
            ctrl_d   = id_valid ? id_ctrl : '0;
            pc_d     = id_pc;
            rs_val_d = id_rs_val;
            rt_val_d = id_rt_val;
            imm_d    = id_imm16;
            rs_d     = id_rs;
            rt_d     = id_rt;
            dest_d   = id_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            pc_q     <= '0;
            rs_val_q <= '0;
            rt_val_q <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            dest_q   <= '0;
            pend_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            rs_val_q <= rs_val_d;
            rt_val_q <= rt_val_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            dest_q   <= dest_d;
            pend_q   <= pend_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_ctrl   = ctrl_q;
    assign ex_pc     = pc_q;
    assign ex_rs_val = rs_val_q;
    assign ex_rt_val = rt_val_q;
    assign ex_imm16  = imm_q;
    assign ex_rs     = rs_q;
    assign ex_rt     = rt_q;
    assign ex_dest   = dest_q;

`ifdef IDEX_PERF_CNT_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q,  flush_cnt_d;

    // Saturating counters; both are implicitly frozen during hold.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (hazard_bubble && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
        if (flush_bubble && flush_cnt_q != 16'hFFFF)   flush_cnt_d  = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed, table-driven bench for id_ex_stage_reg; builds with or without IDEX_PERF_CNT_EN.
module tb_id_ex_stage_reg;

    localparam logic [21:0] SUBU  = 22'h048200;
    localparam logic [21:0] LBU   = 22'h140601;
    localparam logic [21:0] ADDIU = 22'h140600;
    localparam logic [21:0] JAL   = 22'h180200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [21:0] id_ctrl;
    logic [31:0] id_pc, id_rs_val, id_rt_val;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        hold, flush;
    logic        ex_valid;
    logic [21:0] ex_ctrl;
    logic [31:0] ex_pc, ex_rs_val, ex_rt_val;
    logic [15:0] ex_imm16;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic        stall_req;
`ifdef IDEX_PERF_CNT_EN
    logic [15:0] bubble_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_imm16(id_imm16), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .hold(hold), .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
        .ex_imm16(ex_imm16), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
        .stall_req(stall_req)
`ifdef IDEX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    typedef struct {
        logic        vld;
        logic [21:0] ctrl;
        logic [31:0] pc;
        logic [4:0]  rs, rt, rd;
        logic        hold, flush;
        logic        e_stall;
        logic        e_vld;
        logic [21:0] e_ctrl;
        logic [4:0]  e_dest;
        logic [31:0] e_pc;
        logic [4:0]  e_rs, e_rt;
    } vec_t;

    localparam int NV = 15;
    vec_t v [NV];

    // Operand values are derived from the PC so a zeroed bubble maps to all-zero data.
    function automatic logic [31:0] rsv(input logic [31:0] pc);
        return pc * 3;
    endfunction
    function automatic logic [31:0] rtv(input logic [31:0] pc);
        return pc << 4;
    endfunction
    function automatic logic [15:0] immv(input logic [31:0] pc);
        return pc[15:0] * 16'd5;
    endfunction

    function automatic vec_t mk(input logic vld, input logic [21:0] ctrl, input logic [31:0] pc,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic hd, input logic fl, input logic es, input logic ev,
                                input logic [21:0] ec, input logic [4:0] ed, input logic [31:0] ep,
                                input logic [4:0] ers, input logic [4:0] ert);
        vec_t r;
        r.vld = vld; r.ctrl = ctrl; r.pc = pc; r.rs = rs; r.rt = rt; r.rd = rd;
        r.hold = hd; r.flush = fl; r.e_stall = es; r.e_vld = ev; r.e_ctrl = ec;
        r.e_dest = ed; r.e_pc = ep; r.e_rs = ers; r.e_rt = ert;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [21:0] ctrl, input logic [31:0] pc,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic hd, input logic fl);
        id_valid = vld; id_ctrl = ctrl; id_pc = pc;
        id_rs_val = rsv(pc); id_rt_val = rtv(pc); id_imm16 = immv(pc);
        id_rs = rs; id_rt = rt; id_rd = rd; hold = hd; flush = fl;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ex_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, " ex_ctrl"}, {10'd0, ex_ctrl}, 32'd0);
        chk({tag, " ex_dest"}, {27'd0, ex_dest}, 32'd0);
        chk({tag, " ex_pc"}, ex_pc, 32'd0);
        chk({tag, " ex_rs_val"}, ex_rs_val, 32'd0);
        chk({tag, " ex_imm16"}, {16'd0, ex_imm16}, 32'd0);
        chk({tag, " stall_req"}, {31'd0, stall_req}, 32'd0);
    endtask

    initial begin
        v[0]  = mk(0, 22'd0, 32'h0fc, 0, 0, 0, 0, 0,  0, 0, 22'd0, 31, 32'h0fc, 0, 0);
        v[1]  = mk(1, SUBU,  32'h100, 1, 2, 3, 0, 0,  0, 1, SUBU,  3,  32'h100, 1, 2);
        v[2]  = mk(1, LBU,   32'h104, 0, 5, 0, 0, 0,  0, 1, LBU,   5,  32'h104, 0, 5);
        v[3]  = mk(1, SUBU,  32'h108, 5, 2, 6, 0, 0,  1, 0, 22'd0, 0,  32'h0,   0, 0);
        v[4]  = mk(1, SUBU,  32'h108, 5, 2, 6, 0, 0,  0, 1, SUBU,  6,  32'h108, 5, 2);
        v[5]  = mk(1, ADDIU, 32'h10c, 0, 5, 0, 0, 0,  0, 1, ADDIU, 5,  32'h10c, 0, 5);
        v[6]  = mk(1, SUBU,  32'h110, 5, 2, 7, 0, 0,  0, 1, SUBU,  7,  32'h110, 5, 2);
        v[7]  = mk(1, LBU,   32'h114, 0, 0, 0, 0, 0,  0, 1, LBU,   0,  32'h114, 0, 0);
        v[8]  = mk(1, SUBU,  32'h118, 0, 0, 8, 0, 0,  0, 1, SUBU,  8,  32'h118, 0, 0);
        v[9]  = mk(1, LBU,   32'h11c, 0, 9, 0, 0, 0,  0, 1, LBU,   9,  32'h11c, 0, 9);
        v[10] = mk(1, SUBU,  32'h120, 1, 9, 10, 1, 1, 0, 1, LBU,   9,  32'h11c, 0, 9);
        v[11] = mk(1, SUBU,  32'h120, 1, 9, 10, 1, 0, 0, 1, LBU,   9,  32'h11c, 0, 9);
        v[12] = mk(1, SUBU,  32'h120, 1, 9, 10, 0, 0, 0, 0, 22'd0, 0,  32'h0,   0, 0);
        v[13] = mk(1, SUBU,  32'h124, 1, 9, 10, 0, 0, 0, 1, SUBU,  10, 32'h124, 1, 9);
        v[14] = mk(1, JAL,   32'h128, 0, 0, 0, 0, 0,  0, 1, JAL,   31, 32'h128, 0, 0);

        rst_n = 1'b0;
        drive(1, LBU, 32'h200, 5, 5, 5, 0, 0);
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(v[i].vld, v[i].ctrl, v[i].pc, v[i].rs, v[i].rt, v[i].rd, v[i].hold, v[i].flush);
            #1 chk($sformatf("v%0d stall_req", i), {31'd0, stall_req}, {31'd0, v[i].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), {31'd0, ex_valid}, {31'd0, v[i].e_vld});
            chk($sformatf("v%0d ex_ctrl", i), {10'd0, ex_ctrl}, {10'd0, v[i].e_ctrl});
            chk($sformatf("v%0d ex_dest", i), {27'd0, ex_dest}, {27'd0, v[i].e_dest});
            chk($sformatf("v%0d ex_pc", i), ex_pc, v[i].e_pc);
            chk($sformatf("v%0d ex_rs_val", i), ex_rs_val, rsv(v[i].e_pc));
            chk($sformatf("v%0d ex_rt_val", i), ex_rt_val, rtv(v[i].e_pc));
            chk($sformatf("v%0d ex_imm16", i), {16'd0, ex_imm16}, {16'd0, immv(v[i].e_pc)});
            chk($sformatf("v%0d ex_rs", i), {27'd0, ex_rs}, {27'd0, v[i].e_rs});
            chk($sformatf("v%0d ex_rt", i), {27'd0, ex_rt}, {27'd0, v[i].e_rt});
            @(negedge clk);
        end

`ifdef IDEX_PERF_CNT_EN
        chk("bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
        chk("flush_cnt", {16'd0, flush_cnt}, 32'd1);
`endif

        // Asynchronous reset asserted in the middle of a cycle.
        drive(1, SUBU, 32'h300, 1, 2, 3, 0, 0);
        @(posedge clk);
        #1 chk("pre-async ex_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("async");
        @(negedge clk);
        rst_n = 1'b1;

        // Pending flush must not survive a reset.
        drive(1, SUBU, 32'h304, 1, 2, 4, 1, 1);
        @(negedge clk);
        drive(1, SUBU, 32'h308, 1, 2, 5, 0, 0);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("post-reset ex_dest", {27'd0, ex_dest}, 32'd5);
        chk("post-reset ex_pc", ex_pc, 32'h308);
`ifdef IDEX_PERF_CNT_EN
        chk("post-reset flush_cnt", {16'd0, flush_cnt}, 32'd0);
`endif
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
